// File: rtl/screen_flow_ctl.sv
// Screen sequencer: MENU/PLAY/END state, button enables, game-start pulse, click lockout.
// Latency: a press or game flag in cycle N changes screen, enables and game_start in cycle N+1.
// No backpressure: press pulses are acted on only when armed and owned by the screen, never queued.
module screen_flow_ctl #(
    parameter int         LOCKOUT_CYCLES = 6_500_000,
    parameter logic [1:0] SCR_MENU       = 2'd0,
    parameter logic [1:0] SCR_PLAY       = 2'd1,
    parameter logic [1:0] SCR_END        = 2'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mouse_left,
    input  logic       start_pressed,
    input  logic       restart_pressed,
    input  logic       menu_pressed,
    input  logic       game_won,
    input  logic       game_lost,
    output logic [1:0] screen,
    output logic       start_enable,
    output logic       restart_enable,
    output logic       menu_enable,
    output logic       game_enable,
    output logic       game_start,
    output logic       result_win
);

    localparam int                LOCK_W    = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_MENU = SCR_MENU,
        ST_PLAY = SCR_PLAY,
        ST_END  = SCR_END
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_change;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_armed;
    logic              r_start_en;
    logic              r_game_en;
    logic              r_end_en;
    logic              r_game_start;
    logic              r_result_win;

    // State register; the screen output mirrors it directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_MENU;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: presses count only when armed, game flags only in PLAY.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_MENU: begin
                if (start_pressed && r_armed) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (game_won || game_lost) begin
                    w_state_nxt = ST_END;
                end
            end
            ST_END: begin
                if (restart_pressed && r_armed) begin
                    w_state_nxt = ST_PLAY;
                end else if (menu_pressed && r_armed) begin
                    w_state_nxt = ST_MENU;
                end
            end
            default: begin
                // Unused code 2'd3 falls back to the menu.
                w_state_nxt = ST_MENU;
            end
        endcase
    end

    assign w_change = (w_state_nxt != r_state);

    // Lockout: reload on every screen change, count down to 0, then arm once the mouse is up.
    always_ff @(posedge clk) begin
        if (rst || w_change) begin
            r_lock_cnt <= LOCK_INIT;
            r_armed    <= 1'b0;
        end else begin
            if (r_lock_cnt != '0) begin
                r_lock_cnt <= r_lock_cnt - LOCK_W'(1);
            end
            if ((r_lock_cnt == '0) && !mouse_left) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Button enables trail armed by a cycle and drop together with the screen change.
    always_ff @(posedge clk) begin
        if (rst || w_change) begin
            r_start_en <= 1'b0;
            r_game_en  <= 1'b0;
            r_end_en   <= 1'b0;
        end else begin
            r_start_en <= r_armed && (r_state == ST_MENU);
            r_game_en  <= r_armed && (r_state == ST_PLAY);
            r_end_en   <= r_armed && (r_state == ST_END);
        end
    end

    // game_start pulses on entry to PLAY; result_win latches only on leaving PLAY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_game_start <= 1'b0;
            r_result_win <= 1'b0;
        end else begin
            r_game_start <= w_change && (w_state_nxt == ST_PLAY);
            if (w_change && (r_state == ST_PLAY)) begin
                r_result_win <= game_won;
            end
        end
    end

    assign screen         = r_state;
    assign start_enable   = r_start_en;
    assign game_enable    = r_game_en;
    assign restart_enable = r_end_en;
    assign menu_enable    = r_end_en;
    assign game_start     = r_game_start;
    assign result_win     = r_result_win;

endmodule

// File: tb/tb_screen_flow_ctl.sv
// Bench for screen_flow_ctl with a short lockout: fixed vector table, hand-built
// corner sequences, then random stimulus against a cycle-age reference model.
module tb_screen_flow_ctl;

    localparam int L = 4;

    logic       clk = 1'b0;
    logic       rst, mouse_left, start_pressed, restart_pressed, menu_pressed;
    logic       game_won, game_lost;
    logic [1:0] screen;
    logic       start_enable, restart_enable, menu_enable, game_enable;
    logic       game_start, result_win;

    always #5 clk = ~clk;

    screen_flow_ctl #(.LOCKOUT_CYCLES(L)) dut (
        .clk             (clk),
        .rst             (rst),
        .mouse_left      (mouse_left),
        .start_pressed   (start_pressed),
        .restart_pressed (restart_pressed),
        .menu_pressed    (menu_pressed),
        .game_won        (game_won),
        .game_lost       (game_lost),
        .screen          (screen),
        .start_enable    (start_enable),
        .restart_enable  (restart_enable),
        .menu_enable     (menu_enable),
        .game_enable     (game_enable),
        .game_start      (game_start),
        .result_win      (result_win)
    );

    typedef struct {
        bit         r, ms, st, rs, mn, won, lost;
        logic [1:0] scr;
        bit         se, ge, re, gs, win;
    } vec_t;

    vec_t tbl[28];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: age counts edges since the last screen change or reset;
    // the lockout has expired once age reaches L-1.
    logic [1:0] m_scr;
    int         m_age;
    bit         m_armed, m_se, m_ge, m_re, m_gs, m_win;

    function automatic vec_t mk(bit r, bit ms, bit st, bit rs, bit mn, bit won, bit lost,
                                logic [1:0] scr, bit se, bit ge, bit re, bit gs, bit win);
        vec_t v;
        v.r = r; v.ms = ms; v.st = st; v.rs = rs; v.mn = mn; v.won = won; v.lost = lost;
        v.scr = scr; v.se = se; v.ge = ge; v.re = re; v.gs = gs; v.win = win;
        return v;
    endfunction

    task automatic model_step(input bit r, input bit ms, input bit st, input bit rs,
                              input bit mn, input bit won, input bit lost);
        logic [1:0] nxt;
        bit         chg;
        if (r) begin
            m_scr = 2'd0; m_age = 0; m_armed = 0;
            m_se = 0; m_ge = 0; m_re = 0; m_gs = 0; m_win = 0;
        end else begin
            nxt = m_scr;
            case (m_scr)
                2'd0: begin if (st && m_armed) nxt = 2'd1; end
                2'd1: begin if (won || lost) nxt = 2'd2; end
                2'd2: begin
                    if (rs && m_armed) nxt = 2'd1;
                    else if (mn && m_armed) nxt = 2'd0;
                end
                default: nxt = 2'd0;
            endcase
            chg  = (nxt != m_scr);
            m_gs = chg && (nxt == 2'd1);
            if (chg && m_scr == 2'd1) m_win = won;
            if (chg) begin
                m_age = 0; m_armed = 0; m_se = 0; m_ge = 0; m_re = 0;
            end else begin
                m_se = m_armed && (m_scr == 2'd0);
                m_ge = m_armed && (m_scr == 2'd1);
                m_re = m_armed && (m_scr == 2'd2);
                if (m_age >= L - 1 && !ms) m_armed = 1;
                m_age++;
            end
            m_scr = nxt;
        end
    endtask

    task automatic tick(input bit r, input bit ms, input bit st, input bit rs,
                        input bit mn, input bit won, input bit lost);
        rst = r; mouse_left = ms; start_pressed = st; restart_pressed = rs;
        menu_pressed = mn; game_won = won; game_lost = lost;
        @(posedge clk);
        model_step(r, ms, st, rs, mn, won, lost);
        #1;
    endtask

    task automatic check(input string nm, input logic [1:0] scr, input bit se, input bit ge,
                         input bit re, input bit gs, input bit win);
        n_vec++;
        if (screen !== scr || start_enable !== se || game_enable !== ge ||
            restart_enable !== re || menu_enable !== re || game_start !== gs ||
            result_win !== win) begin
            n_bad++;
            $display("FAIL %s: got scr=%0d se=%0b ge=%0b re=%0b me=%0b gs=%0b win=%0b, want scr=%0d se=%0b ge=%0b re=%0b me=%0b gs=%0b win=%0b",
                     nm, screen, start_enable, game_enable, restart_enable, menu_enable,
                     game_start, result_win, scr, se, ge, re, re, gs, win);
        end
    endtask

    task automatic hs(input string nm, input vec_t v);
        tick(v.r, v.ms, v.st, v.rs, v.mn, v.won, v.lost);
        check(nm, v.scr, v.se, v.ge, v.re, v.gs, v.win);
    endtask

    initial begin
        //            r ms st rs mn wn ls   scr se ge re gs win
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // early start ignored
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // armed sets here
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);  // 5th edge after reset
        tbl[7]  = mk(0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 1, 1,   2, 0, 0, 0, 0, 1);  // win beats lose
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1,   2, 0, 0, 0, 0, 1);  // lost ignored in END
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 1, 0, 1);
        tbl[19] = mk(0, 0, 0, 1, 1, 0, 0,   1, 0, 0, 0, 1, 1);  // restart beats menu
        tbl[20] = mk(0, 0, 0, 0, 0, 1, 0,   2, 0, 0, 0, 0, 1);  // flags need no arming
        tbl[21] = mk(0, 0, 1, 0, 0, 0, 0,   2, 0, 0, 0, 0, 1);  // start not owned by END
        tbl[22] = mk(0, 0, 0, 0, 1, 0, 0,   2, 0, 0, 0, 0, 1);  // menu while unarmed
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 1);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 1);
        tbl[25] = mk(0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 1, 0, 1);
        tbl[26] = mk(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 1);  // win retained in MENU
        tbl[27] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1);

        rst = 1; mouse_left = 0; start_pressed = 0; restart_pressed = 0;
        menu_pressed = 0; game_won = 0; game_lost = 0;

        for (int i = 0; i < 28; i++) hs($sformatf("tbl%0d", i), tbl[i]);

        // Mouse held through the lockout keeps the menu disarmed until release.
        hs("held_rst0", mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        hs("held_rst1", mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            hs($sformatf("held%0d", i), mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        hs("held_rel0", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        hs("held_rel1", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        // Reset mid-lockout in PLAY after a won game clears everything.
        hs("mid_rst0", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        hs("mid_rst1", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            hs($sformatf("mid_arm%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        hs("mid_se",    mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        hs("mid_start", mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        hs("mid_won",   mk(0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 1));
        for (int i = 0; i < 4; i++)
            hs($sformatf("mid_end%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1));
        hs("mid_re",    mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 1));
        hs("mid_rs",    mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1));
        hs("mid_lk2",   mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        hs("mid_rst",   mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            hs($sformatf("mid_re_arm%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        hs("mid_re_se", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        // Random traffic against the reference model.
        tick(1, 0, 0, 0, 0, 0, 0);
        check("rand_rst", m_scr, m_se, m_ge, m_re, m_gs, m_win);
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 299) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 11) == 0);
            check($sformatf("rand%0d", i), m_scr, m_se, m_ge, m_re, m_gs, m_win);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/screen_flow_ctl.md
Name: screen_flow_ctl

Overview:
- Top-level screen sequencer that sits directly downstream of the button controllers. It consumes their one-cycle button_pressed pulses and the game logic's win/lose flags.
- It drives the per-button enable inputs, the screen selector for the VGA mux, and the game-start pulse.
- It enforces a click lockout on every screen change. A mouse press that triggers a button cannot also trigger a button at the same position on the next screen.

Parameters:
- LOCKOUT_CYCLES, 6_500_000, minimum cycles after a screen change before any button is armed (100 ms at 65 MHz); legal range >= 1.
- SCR_MENU, 2'd0, screen code for the menu screen.
- SCR_PLAY, 2'd1, screen code for the game screen.
- SCR_END, 2'd2, screen code for the result screen.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; synchronous, active-high.
- mouse_left  in  1  raw left-button level, same signal that feeds the button controllers.
- start_pressed  in  1  one-cycle pulse from the menu Start button controller.
- restart_pressed  in  1  one-cycle pulse from the result-screen Restart button controller.
- menu_pressed  in  1  one-cycle pulse from the result-screen Menu button controller.
- game_won  in  1  level/pulse from game logic: board solved.
- game_lost  in  1  level/pulse from game logic: out of moves or time.
- screen  out  2  current screen code, to the VGA background/overlay mux.
- start_enable  out  1  enable for the Start button controller.
- restart_enable  out  1  enable for the Restart button controller.
- menu_enable  out  1  enable for the Menu button controller.
- game_enable  out  1  enable for the card-grid input logic.
- game_start  out  1  one-cycle pulse; game logic clears its board/score on it.
- result_win  out  1  latched outcome of the last game (1 = won), valid in SCR_END.

Behaviour:
- Fully synchronous; all outputs registered.
- Reset values: screen=SCR_MENU, all enables=0, game_start=0, result_win=0, lock_cnt=LOCKOUT_CYCLES-1, armed=0.
- State register holds MENU, PLAY or END; screen mirrors it. The unused code 2'd3 recovers to MENU on the next clock.
- Lockout:
  - On every state transition (and out of reset), lock_cnt is loaded with LOCKOUT_CYCLES-1 and armed is cleared.
  - While lock_cnt != 0 it decrements by 1 per cycle. It saturates at 0 and never wraps.
  - armed sets in the first cycle where lock_cnt == 0 and mouse_left == 0. A button held through the lockout therefore keeps armed low until it is released.
  - Once set, armed stays 1 until the next transition.
  - Counter width is $clog2(LOCKOUT_CYCLES+1).
- Enables: start_enable = armed & MENU; game_enable = armed & PLAY; restart_enable = menu_enable = armed & END.
  - Enables are registered: they rise the cycle after armed sets and fall in the same cycle screen changes.
- Transitions are evaluated only on the current cycle's inputs:
  - MENU: start_pressed & armed -> PLAY, with game_start=1 for exactly the first cycle in PLAY.
  - PLAY: game_won -> END with result_win=1. Otherwise game_lost -> END with result_win=0.
    - Win has priority when both are asserted.
    - Game flags are accepted regardless of armed.
  - END: restart_pressed & armed -> PLAY, with a game_start pulse. Otherwise menu_pressed & armed -> MENU.
    - Restart has priority when both pulses arrive in the same cycle.
- Press pulses are ignored when armed=0 or when the current state does not own that button; no queuing.
- game_won/game_lost are ignored outside PLAY.
- result_win updates only on the PLAY->END transition and holds otherwise, including through MENU.
- Latency: press pulse in cycle N -> screen, enable drop and game_start in cycle N+1.
- rst asserted mid-lockout or mid-game: it overrides everything in that cycle and returns to the reset values.

Test Plan (LOCKOUT_CYCLES=4):
- Reset, then hold mouse_left=1 for 10 cycles and release -> start_enable stays 0 while held. armed sets the first cycle after release (lock_cnt already 0); start_enable=1 one cycle later.
- Reset, mouse_left=0 -> start_enable=1 exactly 5 cycles after rst deasserts. A start_pressed pulse issued before then is ignored and screen stays 0.
- Armed MENU, start_pressed pulse -> next cycle: screen=1, game_start=1 for one cycle, start_enable=0. game_enable=1 after 4+1 cycles with mouse released.
- PLAY, game_won and game_lost together -> next cycle: screen=2, result_win=1. Then game_lost alone in END -> no change.
- Armed END, restart_pressed and menu_pressed in the same cycle -> screen=1 with a game_start pulse. Separately, menu_pressed alone -> screen=0, result_win retained.
- rst asserted at lock_cnt=2 in PLAY -> next cycle: screen=0, all enables=0, game_start=0, result_win=0, lockout restarts from 3.
